// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit pipeline: branch condition codes, flag bit positions, widths.
// No logic; latency and backpressure not applicable.
// Imported by the execute/commit RTL.
package cpu_pkg;

    localparam int CPU_DATA_W = 16;

    localparam logic [2:0] COND_NE  = 3'b000;
    localparam logic [2:0] COND_EQ  = 3'b001;
    localparam logic [2:0] COND_GT  = 3'b010;
    localparam logic [2:0] COND_LT  = 3'b011;
    localparam logic [2:0] COND_GE  = 3'b100;
    localparam logic [2:0] COND_LE  = 3'b101;
    localparam logic [2:0] COND_OV  = 3'b110;
    localparam logic [2:0] COND_UNC = 3'b111;

    localparam int FLAG_V = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 0;

    typedef enum logic {
        SQ_IDLE   = 1'b0,
        SQ_SQUASH = 1'b1
    } sq_state_e;

endpackage

// File: rtl/ex_commit_if.sv
// Execute -> EX/MEM boundary bundle: instruction fields in, registered MEM-stage view out.
// No logic; stall/flush travel with the bundle as the pipeline control pair.
// master = execute stage side, slave = ex_commit.
interface ex_commit_if #(
    parameter int DATA_W = 16,
    parameter int RDST_W = 4
);
    logic              stall;
    logic              flush;
    logic              in_valid;
    logic [DATA_W-1:0] dst;
    logic              V;
    logic              Z;
    logic              N;
    logic              set_flags;
    logic              is_branch;
    logic [2:0]        cond;
    logic [DATA_W-1:0] addResult;
    logic [RDST_W-1:0] wb_reg;
    logic              wb_en;

    logic              mem_valid;
    logic [DATA_W-1:0] mem_dst;
    logic [RDST_W-1:0] mem_wb_reg;
    logic              mem_wb_en;
    logic [2:0]        flags_q;
    logic              branch_taken;
    logic [DATA_W-1:0] branch_target;

    modport master (
        output stall, flush, in_valid, dst, V, Z, N, set_flags, is_branch, cond, addResult,
               wb_reg, wb_en,
        input  mem_valid, mem_dst, mem_wb_reg, mem_wb_en, flags_q, branch_taken, branch_target
    );

    modport slave (
        input  stall, flush, in_valid, dst, V, Z, N, set_flags, is_branch, cond, addResult,
               wb_reg, wb_en,
        output mem_valid, mem_dst, mem_wb_reg, mem_wb_en, flags_q, branch_taken, branch_target
    );
endinterface

// File: rtl/ex_commit_branch_cond.sv
// Branch condition resolver: condition code against architectural {V,Z,N}.
// Latency 0 (purely combinational).
// No backpressure; evaluated every cycle.
module branch_cond
    import cpu_pkg::*;
(
    input  logic [2:0] cond,
    input  logic [2:0] flags,
    output logic       taken
);
    logic v;
    logic z;
    logic n;

    assign v = flags[FLAG_V];
    assign z = flags[FLAG_Z];
    assign n = flags[FLAG_N];

    always_comb begin
        taken = 1'b0;
        case (cond)
            COND_NE:  taken = !z;
            COND_EQ:  taken = z;
            COND_GT:  taken = !z && !n;
            COND_LT:  taken = n;
            COND_GE:  taken = z || !n;
            COND_LE:  taken = z || n;
            COND_OV:  taken = v;
            COND_UNC: taken = 1'b1;
            default:  taken = 1'b0;
        endcase
    end
endmodule

// File: rtl/ex_commit.sv
// EX/MEM commit register: owns flags, resolves branches, squashes the wrong-path shadow.
// Latency 1 cycle; stall holds every register, flush clears in-flight state but keeps flags.
// Optional BRANCH_STATS_EN adds saturating branch counters br_seen / br_taken_cnt.
module ex_commit
    import cpu_pkg::*;
#(
    parameter int DATA_W = CPU_DATA_W,
    parameter int RDST_W = 4,
    parameter int SHADOW = 2
) (
    input  logic        clk,
    input  logic        rst,
    ex_commit_if.slave  bus
`ifdef BRANCH_STATS_EN
    ,
    output logic [15:0] br_seen,
    output logic [15:0] br_taken_cnt
`endif
);
    logic              mem_valid_q,     mem_valid_d;
    logic [DATA_W-1:0] mem_dst_q,       mem_dst_d;
    logic [RDST_W-1:0] mem_wb_reg_q,    mem_wb_reg_d;
    logic              mem_wb_en_q,     mem_wb_en_d;
    logic [2:0]        flags_q,         flags_d;
    logic              branch_taken_q,  branch_taken_d;
    logic [DATA_W-1:0] branch_target_q, branch_target_d;
    logic [1:0]        sq_cnt_q,        sq_cnt_d;
    sq_state_e         state_q,         state_d;

    logic accept;
    logic cond_taken;

    branch_cond u_branch_cond (
        .cond  (bus.cond),
        .flags (flags_q),
        .taken (cond_taken)
    );

    assign accept = bus.in_valid && !bus.stall && !bus.flush && (state_q == SQ_IDLE);

    always_comb begin
        mem_valid_d     = mem_valid_q;
        mem_dst_d       = mem_dst_q;
        mem_wb_reg_d    = mem_wb_reg_q;
        mem_wb_en_d     = mem_wb_en_q;
        flags_d         = flags_q;
        branch_taken_d  = branch_taken_q;
        branch_target_d = branch_target_q;
        sq_cnt_d        = sq_cnt_q;

        if (bus.flush) begin
            mem_valid_d    = 1'b0;
            mem_wb_en_d    = 1'b0;
            branch_taken_d = 1'b0;
            sq_cnt_d       = 2'd0;
        end else if (!bus.stall) begin
            mem_valid_d    = accept;
            mem_wb_en_d    = accept && bus.wb_en && !bus.is_branch;
            branch_taken_d = 1'b0;
            if (accept) begin
                mem_dst_d    = bus.dst;
                mem_wb_reg_d = bus.wb_reg;
                if (!bus.is_branch && bus.set_flags) begin
                    flags_d = {bus.V, bus.Z, bus.N};
                end
                if (bus.is_branch && cond_taken) begin
                    branch_taken_d  = 1'b1;
                    branch_target_d = bus.addResult;
                    sq_cnt_d        = 2'(SHADOW);
                end
            end else if (state_q == SQ_SQUASH && bus.in_valid) begin
                // only real wrong-path instructions consume the shadow
                sq_cnt_d = sq_cnt_q - 2'd1;
            end
        end

        state_d = (sq_cnt_d != 2'd0) ? SQ_SQUASH : SQ_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_valid_q     <= 1'b0;
            mem_dst_q       <= '0;
            mem_wb_reg_q    <= '0;
            mem_wb_en_q     <= 1'b0;
            flags_q         <= 3'b000;
            branch_taken_q  <= 1'b0;
            branch_target_q <= '0;
            sq_cnt_q        <= 2'd0;
            state_q         <= SQ_IDLE;
        end else begin
            mem_valid_q     <= mem_valid_d;
            mem_dst_q       <= mem_dst_d;
            mem_wb_reg_q    <= mem_wb_reg_d;
            mem_wb_en_q     <= mem_wb_en_d;
            flags_q         <= flags_d;
            branch_taken_q  <= branch_taken_d;
            branch_target_q <= branch_target_d;
            sq_cnt_q        <= sq_cnt_d;
            state_q         <= state_d;
        end
    end

    assign bus.mem_valid     = mem_valid_q;
    assign bus.mem_dst       = mem_dst_q;
    assign bus.mem_wb_reg    = mem_wb_reg_q;
    assign bus.mem_wb_en     = mem_wb_en_q;
    assign bus.flags_q       = flags_q;
    assign bus.branch_taken  = branch_taken_q;
    assign bus.branch_target = branch_target_q;

`ifdef BRANCH_STATS_EN
    logic [15:0] br_seen_q,  br_seen_d;
    logic [15:0] br_taken_q, br_taken_d;

    always_comb begin
        br_seen_d  = br_seen_q;
        br_taken_d = br_taken_q;
        if (accept && bus.is_branch && br_seen_q != 16'hFFFF) begin
            br_seen_d = br_seen_q + 16'd1;
        end
        if (accept && bus.is_branch && cond_taken && br_taken_q != 16'hFFFF) begin
            br_taken_d = br_taken_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            br_seen_q  <= 16'd0;
            br_taken_q <= 16'd0;
        end else begin
            br_seen_q  <= br_seen_d;
            br_taken_q <= br_taken_d;
        end
    end

    assign br_seen      = br_seen_q;
    assign br_taken_cnt = br_taken_q;
`endif

endmodule
